// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM responder: state encoding, default error word, range check.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sram_pkg;

    // Word returned on a read that falls outside the mapped window.
    localparam logic [31:0] SRAM_ERR_DATA = 32'hDEAD_BEEF;

    // Word index width for the default 4096-word configuration.
    localparam int unsigned SRAM_IDX_W = 12;

    typedef logic [SRAM_IDX_W-1:0] word_idx_t;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } sram_state_e;

    // True when addr lies inside [base, base + depth*4). The subtraction wraps, so an address
    // below base becomes a huge offset and is rejected by the same compare.
    function automatic logic sram_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [32:0] off;
        logic [32:0] lim;
        off = {1'b0, addr - base};
        lim = 33'(depth) << 2;
        return off < lim;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// DEPTH x 32 storage: port A read/write with byte-lane enables, port B read-only.
// Latency: 1 cycle, read-first (port A returns the word as it was before the write).
// Backpressure: none; accepts an access every cycle, output holds while the port is idle.
//
// Ports:
//   clk                    rising-edge clock
//   a_en/a_we/a_addr/a_wdata/a_rdata   read/write port, a_we bit i writes byte lane i
//   b_en/b_addr/b_rdata                read-only port
module sram_bank #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic [3:0]    a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic [31:0]   a_rdata,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [31:0]   b_rdata
);

    logic [31:0] mem [DEPTH];

    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;

    // Output registers capture the pre-write contents and hold while the port is idle.
    always_comb begin
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (a_en) a_rdata_d = mem[a_addr];
        if (b_en) b_rdata_d = mem[b_addr];
    end

    always_ff @(posedge clk) begin
        a_rdata_q <= a_rdata_d;
        b_rdata_q <= b_rdata_d;
        if (a_en) begin
            for (int i = 0; i < 4; i++) begin
                if (a_we[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Responder for the core's inst_sram/data_sram ports: decode, optional power-on clear, error counting.
// Latency: read data registered, valid the cycle after the request; stores are read-first.
// Backpressure: none; requests are dropped while the clear is running (init_done low).
//
// Ports: clk, resetn (sync, active low); inst_sram_* read-only fetch port (any write enable is an
// error); data_sram_* load/store port with byte enables; init_done; err_count (saturating).
// Build option: define SRAM_CLEAR_EN to zero the whole array after every reset before serving.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h1FC0_0000,
    parameter logic [31:0] ERR_DATA  = SRAM_ERR_DATA
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        init_done,
    output logic [15:0] err_count
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef SRAM_CLEAR_EN
    localparam sram_state_e RESET_STATE = S_CLEAR;
`else
    localparam sram_state_e RESET_STATE = S_READY;
`endif

    // Address decode
    logic [31:0]   inst_off, data_off;
    logic [AW-1:0] inst_idx, data_idx;
    logic          inst_in, data_in;

    assign inst_off = inst_sram_addr - BASE_ADDR;
    assign data_off = data_sram_addr - BASE_ADDR;
    assign inst_idx = inst_off[AW+1:2];
    assign data_idx = data_off[AW+1:2];
    assign inst_in  = sram_in_range(inst_sram_addr, BASE_ADDR, DEPTH);
    assign data_in  = sram_in_range(data_sram_addr, BASE_ADDR, DEPTH);

    // Offset bits outside the word index and the fetch port's store data carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{inst_sram_wdata, inst_off[31:AW+2], inst_off[1:0],
                           data_off[31:AW+2], data_off[1:0]};

    // State
    sram_state_e state_q, state_d;
    logic [15:0] err_count_q, err_count_d;
    // Output source per port: mem_sel picks the bank register, otherwise err_sel picks
    // ERR_DATA vs zero. Held together with the bank register while the port is idle.
    logic        inst_mem_sel_q, inst_mem_sel_d;
    logic        inst_err_sel_q, inst_err_sel_d;
    logic        data_mem_sel_q, data_mem_sel_d;
    logic        data_err_sel_q, data_err_sel_d;
`ifdef SRAM_CLEAR_EN
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
`endif

    // Bank control
    logic          bank_a_en, bank_b_en;
    logic [3:0]    bank_a_we;
    logic [AW-1:0] bank_a_addr, bank_b_addr;
    logic [31:0]   bank_a_wdata, bank_a_rdata, bank_b_rdata;

    logic [1:0]  err_add;
    logic [16:0] err_sum;

    always_comb begin
        state_d        = state_q;
        inst_mem_sel_d = inst_mem_sel_q;
        inst_err_sel_d = inst_err_sel_q;
        data_mem_sel_d = data_mem_sel_q;
        data_err_sel_d = data_err_sel_q;
`ifdef SRAM_CLEAR_EN
        clr_ptr_d      = clr_ptr_q;
`endif
        bank_a_en      = 1'b0;
        bank_a_we      = 4'h0;
        bank_a_addr    = data_idx;
        bank_a_wdata   = data_sram_wdata;
        bank_b_en      = 1'b0;
        bank_b_addr    = inst_idx;
        err_add        = 2'd0;

        if (state_q == S_READY) begin
            // Fetch port: a write attempt is flagged but the read is still served.
            if (inst_sram_en) begin
                bank_b_en      = inst_in;
                inst_mem_sel_d = inst_in;
                inst_err_sel_d = !inst_in;
                if (!inst_in || (inst_sram_wen != 4'h0)) err_add = err_add + 2'd1;
            end
            // Data port: out-of-range stores are dropped by never enabling the bank.
            if (data_sram_en) begin
                bank_a_en      = data_in;
                bank_a_we      = data_sram_wen;
                data_mem_sel_d = data_in;
                data_err_sel_d = !data_in;
                if (!data_in) err_add = err_add + 2'd1;
            end
        end
`ifdef SRAM_CLEAR_EN
        else begin
            // One word zeroed per cycle through the read/write port; requests ignored.
            bank_a_en      = 1'b1;
            bank_a_we      = 4'hF;
            bank_a_addr    = clr_ptr_q;
            bank_a_wdata   = 32'h0;
            inst_mem_sel_d = 1'b0;
            inst_err_sel_d = 1'b0;
            data_mem_sel_d = 1'b0;
            data_err_sel_d = 1'b0;
            clr_ptr_d      = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(DEPTH - 1)) state_d = S_READY;
        end
`endif

        err_sum     = {1'b0, err_count_q} + {15'd0, err_add};
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= RESET_STATE;
            err_count_q    <= 16'h0;
            inst_mem_sel_q <= 1'b0;
            inst_err_sel_q <= 1'b0;
            data_mem_sel_q <= 1'b0;
            data_err_sel_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            err_count_q    <= err_count_d;
            inst_mem_sel_q <= inst_mem_sel_d;
            inst_err_sel_q <= inst_err_sel_d;
            data_mem_sel_q <= data_mem_sel_d;
            data_err_sel_q <= data_err_sel_d;
        end
    end

`ifdef SRAM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!resetn) clr_ptr_q <= '0;
        else         clr_ptr_q <= clr_ptr_d;
    end
`endif

    sram_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk     (clk),
        .a_en    (bank_a_en),
        .a_we    (bank_a_we),
        .a_addr  (bank_a_addr),
        .a_wdata (bank_a_wdata),
        .a_rdata (bank_a_rdata),
        .b_en    (bank_b_en),
        .b_addr  (bank_b_addr),
        .b_rdata (bank_b_rdata)
    );

    assign inst_sram_rdata = inst_mem_sel_q ? bank_b_rdata : (inst_err_sel_q ? ERR_DATA : 32'h0);
    assign data_sram_rdata = data_mem_sel_q ? bank_a_rdata : (data_err_sel_q ? ERR_DATA : 32'h0);
    assign init_done       = (state_q == S_READY);
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: word-level memory model plus directed vectors.
// Inputs change 1 ns after the rising edge, the model updates on the rising edge,
// and the compare process checks every falling edge once the first reset has been seen.
module tb_sram_responder;

    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h1FC0_0000;
    localparam logic [31:0] ERRW  = 32'hDEAD_BEEF;
`ifdef SRAM_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_en, data_sram_en;
    logic [3:0]  inst_sram_wen, data_sram_wen;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        init_done;
    logic [15:0] err_count;

    sram_responder dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .init_done       (init_done),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mmem [DEPTH];
    logic [3:0]  mval [DEPTH];     // which bytes of each word hold a known value
    bit          started = 1'b0;
    int          clear_left = 0;
    logic [31:0] m_irdat, m_drdat;
    bit          m_ik = 1'b0, m_dk = 1'b0;
    int          m_err = 0;
    int          m_e;
    int unsigned m_w;

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off / 4;
    endfunction

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mval[i] = 4'h0;
    end

    always @(posedge clk) begin
        if (!resetn) begin
            started    = 1'b1;
            m_irdat    = 32'h0; m_ik = 1'b1;
            m_drdat    = 32'h0; m_dk = 1'b1;
            m_err      = 0;
            clear_left = CLEAR_EN ? int'(DEPTH) : 0;
        end else if (started) begin
            if (clear_left != 0) begin
                clear_left--;
                m_irdat = 32'h0; m_ik = 1'b1;
                m_drdat = 32'h0; m_dk = 1'b1;
                if (clear_left == 0) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        mmem[i] = 32'h0;
                        mval[i] = 4'hF;
                    end
                end
            end else begin
                m_e = 0;
                // Reads first, so a same-cycle store is invisible to either port.
                if (inst_sram_en) begin
                    if (in_rng(inst_sram_addr)) begin
                        m_w     = widx(inst_sram_addr);
                        m_irdat = mmem[m_w];
                        m_ik    = (mval[m_w] == 4'hF);
                    end else begin
                        m_irdat = ERRW; m_ik = 1'b1;
                    end
                    if (!in_rng(inst_sram_addr) || inst_sram_wen != 4'h0) m_e++;
                end
                if (data_sram_en) begin
                    if (in_rng(data_sram_addr)) begin
                        m_w     = widx(data_sram_addr);
                        m_drdat = mmem[m_w];
                        m_dk    = (mval[m_w] == 4'hF);
                        for (int b = 0; b < 4; b++) begin
                            if (data_sram_wen[b]) begin
                                mmem[m_w][8*b +: 8] = data_sram_wdata[8*b +: 8];
                                mval[m_w][b]        = 1'b1;
                            end
                        end
                    end else begin
                        m_drdat = ERRW; m_dk = 1'b1;
                        m_e++;
                    end
                end
                m_err = (m_err + m_e > 65535) ? 65535 : m_err + m_e;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("init_done", {31'd0, init_done}, {31'd0, clear_left == 0});
            chk("err_count", {16'd0, err_count}, 32'(m_err));
            if (m_ik) chk("inst_rdata", inst_sram_rdata, m_irdat);
            if (m_dk) chk("data_rdata", data_sram_rdata, m_drdat);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ie, input logic [3:0] iw, input logic [31:0] ia,
                         input logic de, input logic [3:0] dw, input logic [31:0] da,
                         input logic [31:0] dd);
        inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia;
        data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
        step();
        inst_sram_en = 1'b0; inst_sram_wen = 4'h0;
        data_sram_en = 1'b0; data_sram_wen = 4'h0;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_done !== 1'b1 && n < int'(DEPTH) + 16) begin
            step();
            n++;
        end
    endtask

    int n;

    initial begin
        resetn          = 1'b0;
        inst_sram_en    = 1'b0; inst_sram_wen = 4'h0; inst_sram_addr = 32'h0;
        inst_sram_wdata = 32'hFFFF_FFFF;   // would corrupt memory if a fetch-port write leaked
        data_sram_en    = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0;
        data_sram_wdata = 32'h0;

        // 1: reset and initialisation
        repeat (3) step();
        chk("rst_inst_rdata", inst_sram_rdata, 32'h0);
        chk("rst_data_rdata", data_sram_rdata, 32'h0);
        chk("rst_err_count", {16'd0, err_count}, 32'h0);
        resetn = 1'b1;
        wait_init(n);
        chk("init_cycles", 32'(n), CLEAR_EN ? DEPTH : 32'd0);
`ifndef SRAM_CLEAR_EN
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, BASE,     32'h0);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, BASE + 4, 32'h0);
`endif
        drive(1'b1, 4'h0, BASE, 1'b1, 4'h0, BASE + 4, 32'h0);
        chk("rd_base", inst_sram_rdata, 32'h0);
        chk("rd_base4", data_sram_rdata, 32'h0);

        // 2: full-word store, byte-lane merge, read-first return
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'hF,    BASE + 8, 32'h1122_3344);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'b0010, BASE + 8, 32'h0000_AB00);
        chk("store_read_first", data_sram_rdata, 32'h1122_3344);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0,    BASE + 8, 32'h0);
        chk("byte_merge", data_sram_rdata, 32'h1122_AB44);

        // 3: back-to-back fetches
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, BASE,     32'h0000_00A0);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, BASE + 4, 32'h0000_00A4);
        drive(1'b1, 4'h0, BASE,     1'b0, 4'h0, 32'h0, 32'h0);
        chk("fetch0", inst_sram_rdata, 32'h0000_00A0);
        drive(1'b1, 4'h0, BASE + 4, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("fetch1", inst_sram_rdata, 32'h0000_00A4);
        drive(1'b1, 4'h0, BASE + 8, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("fetch2", inst_sram_rdata, 32'h1122_AB44);

        // 4: fetch and store to the same word in one cycle
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, BASE + 12, 32'h0000_0001);
        drive(1'b1, 4'h0, BASE + 12, 1'b1, 4'hF, BASE + 12, 32'hCAFE_F00D);
        chk("collide_inst_old", inst_sram_rdata, 32'h0000_0001);
        chk("collide_data_old", data_sram_rdata, 32'h0000_0001);
        drive(1'b1, 4'h0, BASE + 12, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("collide_reread", inst_sram_rdata, 32'hCAFE_F00D);

        // 5: out-of-range read plus fetch-port write attempt in one cycle
        drive(1'b1, 4'h1, BASE + 8, 1'b1, 4'h0, BASE + DEPTH * 4, 32'h0);
        chk("oor_data", data_sram_rdata, ERRW);
        chk("wen_inst_served", inst_sram_rdata, 32'h1122_AB44);
        chk("err_two", {16'd0, err_count}, 32'd2);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, BASE + 8, 32'h0);
        chk("inst_write_dropped", data_sram_rdata, 32'h1122_AB44);
        // last in-range word, then a store just below BASE that must not alias onto it
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, BASE + DEPTH * 4 - 4, 32'h5A5A_0FF0);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, BASE - 4, 32'h1234_5678);
        chk("err_three", {16'd0, err_count}, 32'd3);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, BASE + DEPTH * 4 - 4, 32'h0);
        chk("last_word_intact", data_sram_rdata, 32'h5A5A_0FF0);

        // 6a: idle cycle holds both read registers
        idle();
        chk("hold_inst", inst_sram_rdata, 32'h1122_AB44);
        chk("hold_data", data_sram_rdata, 32'h5A5A_0FF0);

        // error counter saturation: 3 + 2*32765 = 65533, +1 = 65534, +2 -> clamps at 65535
        for (int i = 0; i < 32765; i++)
            drive(1'b1, 4'h1, BASE, 1'b1, 4'h0, BASE + DEPTH * 4, 32'h0);
        chk("err_65533", {16'd0, err_count}, 32'd65533);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, BASE + DEPTH * 4, 32'h0);
        chk("err_65534", {16'd0, err_count}, 32'd65534);
        drive(1'b1, 4'h1, BASE, 1'b1, 4'h0, BASE + DEPTH * 4, 32'h0);
        chk("err_sat", {16'd0, err_count}, 32'hFFFF);
        drive(1'b1, 4'h1, BASE, 1'b1, 4'h0, BASE + DEPTH * 4, 32'h0);
        chk("err_sat_hold", {16'd0, err_count}, 32'hFFFF);

        // 6b: reset again
`ifdef SRAM_CLEAR_EN
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        repeat (100) step();
        chk("midclear_busy", {31'd0, init_done}, 32'd0);
        resetn = 1'b0;
        step();
        chk("midclear_err_rst", {16'd0, err_count}, 32'd0);
        resetn = 1'b1;
        wait_init(n);
        chk("restart_cycles", 32'(n), DEPTH);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, BASE + 8, 32'h0);
        chk("cleared_word", data_sram_rdata, 32'h0);
`else
        resetn = 1'b0;
        step();
        chk("rerst_err", {16'd0, err_count}, 32'd0);
        resetn = 1'b1;
        wait_init(n);
        chk("rerst_init_cycles", 32'(n), 32'd0);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, BASE + 8, 32'h0);
        chk("contents_kept", data_sram_rdata, 32'h1122_AB44);
`endif
        idle();
        chk("final_hold", data_sram_rdata, CLEAR_EN ? 32'h0 : 32'h1122_AB44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
